// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Contents: the controller state encodings (IDLE, ACCESS, CAPTURE) and the
// owner codes that identify which requester holds the RAM port.
package cpu_pkg;

    // Controller states
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    // Requester identities
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

endpackage

// File: rtl/arb_select.sv
// Combinational winner selection between the CPU and IO requesters.
// Optional feature macro: ROUND_ROBIN_EN (fairness based on last-served pointer).
// Ports:
//   cpu_req  in   CPU request
//   io_req   in   IO request
//   last     in   last-served requester (only with ROUND_ROBIN_EN)
//   winner   out  selected requester (OWN_CPU / OWN_IO)
//   valid    out  at least one request present
module arb_select
    import cpu_pkg::*;
(
    input  logic cpu_req,
    input  logic io_req,
`ifdef ROUND_ROBIN_EN
    input  logic last,
`endif
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = cpu_req | io_req;
        winner = OWN_CPU;
`ifdef ROUND_ROBIN_EN
        // On a tie, serve whoever was not served last.
        if (cpu_req && io_req) begin
            winner = (last == OWN_CPU) ? OWN_IO : OWN_CPU;
        end else if (io_req) begin
            winner = OWN_IO;
        end
`else
        // Fixed priority: IO only wins when the CPU is not asking.
        if (!cpu_req && io_req) begin
            winner = OWN_IO;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory RAM port between the CPU load/store path and
// the IO unit. Each access takes IDLE -> ACCESS -> CAPTURE and completes with
// a one-cycle done pulse to the owner, whose rdata register then holds the
// RAM read data.
// Optional feature macro: ROUND_ROBIN_EN (alternate on simultaneous requests;
// default build gives the CPU fixed priority).
// Ports:
//   clk, reset (async, active-high)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  in   CPU access request
//   cpu_done/cpu_rdata                 out  CPU completion pulse / load data
//   cpu_stall                          out  combinational PC freeze
//   io_req/io_we/io_addr/io_wdata      in   IO access request
//   io_done/io_rdata                   out  IO completion pulse / load data
//   mem_addr/mem_wdata/mem_we          out  registered RAM controls
//   mem_rdata                          in   RAM read data (one clk after addr)
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_done,
    output logic [DATA_W-1:0] io_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        state_q,     state_d;
    logic              owner_q,     owner_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q,    mem_we_d;
    logic              cpu_done_q,  cpu_done_d;
    logic              io_done_q,   io_done_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] io_rdata_q,  io_rdata_d;
`ifdef ROUND_ROBIN_EN
    logic              last_q,      last_d;
`endif

    logic sel_winner;
    logic sel_valid;

    arb_select u_arb_select (
        .cpu_req (cpu_req),
        .io_req  (io_req),
`ifdef ROUND_ROBIN_EN
        .last    (last_q),
`endif
        .winner  (sel_winner),
        .valid   (sel_valid)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        cpu_done_d  = 1'b0;
        io_done_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        io_rdata_d  = io_rdata_q;
`ifdef ROUND_ROBIN_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                // A req high in the done cycle is treated as a new request.
                if (sel_valid) begin
                    owner_d = sel_winner;
                    state_d = ACCESS;
`ifdef ROUND_ROBIN_EN
                    last_d  = sel_winner;
`endif
                    if (sel_winner == OWN_IO) begin
                        mem_addr_d  = io_addr;
                        mem_wdata_d = io_wdata;
                        mem_we_d    = io_we;
                    end else begin
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        mem_we_d    = cpu_we;
                    end
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Stores capture the read data too; only the owner is touched.
                if (owner_q == OWN_IO) begin
                    io_rdata_d = mem_rdata;
                    io_done_d  = 1'b1;
                end else begin
                    cpu_rdata_d = mem_rdata;
                    cpu_done_d  = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_done_q  <= 1'b0;
            io_done_q   <= 1'b0;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
`ifdef ROUND_ROBIN_EN
            last_q      <= OWN_CPU;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_done_q  <= cpu_done_d;
            io_done_q   <= io_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_rdata_q  <= io_rdata_d;
`ifdef ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_done  = cpu_done_q;
    assign io_done   = io_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign io_rdata  = io_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter, with a small
// read-first RAM model (unwritten words read as 0x1000_0000 + index).
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              io_req, io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_done;
    logic [DATA_W-1:0] io_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    bit [DATA_W-1:0] ram [16];
    bit [15:0]       wr_mask;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_done   (io_done),
        .io_rdata  (io_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    // RAM model: synchronous read-first
    always @(posedge clk) begin
        if (mem_we) begin
            ram[4'(mem_addr)]     <= mem_wdata;
            wr_mask[4'(mem_addr)] <= 1'b1;
        end
        mem_rdata <= wr_mask[4'(mem_addr)] ? ram[4'(mem_addr)]
                                           : DATA_W'(32'h1000_0000) + DATA_W'(4'(mem_addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
        checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata got=%0h exp=0", mem_wdata); end
        checks++; if (cpu_done !== 1'b0 || io_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b%0b exp=00", cpu_done, io_done); end
        checks++; if (cpu_rdata !== 32'd0 || io_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%0h/%0h exp=0/0", cpu_rdata, io_rdata); end
        cpu_req = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL reset_stall_hi got=%0b exp=1", cpu_stall); end
        cpu_req = 1'b0;
        #1;
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_lo got=%0b exp=0", cpu_stall); end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (cpu_done !== 1'b0 || io_done !== 1'b0 || mem_we !== 1'b0) begin
                failures++; $display("FAIL idle_quiet c=%0d got done=%0b%0b we=%0b exp=000", c, cpu_done, io_done, mem_we);
            end
        end
    endtask

    task automatic test_cpu_store();
        logic exp;
        for (int c = 0; c <= 5; c++) begin
            tick();
            exp = (c == 1);
            checks++; if (mem_we !== exp) begin failures++; $display("FAIL store_mem_we c=%0d got=%0b exp=%0b", c, mem_we, exp); end
            if (c == 1) begin
                checks++; if (mem_addr !== 32'd5 || mem_wdata !== 32'hDEADBEEF) begin
                    failures++; $display("FAIL store_addr_data got=%0h/%0h exp=5/deadbeef", mem_addr, mem_wdata);
                end
            end
            exp = (c == 3);
            checks++; if (cpu_done !== exp) begin failures++; $display("FAIL store_done c=%0d got=%0b exp=%0b", c, cpu_done, exp); end
            if (c == 0) begin
                cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'hDEADBEEF; cpu_req = 1'b1;
            end
            if (c == 3) begin
                cpu_req = 1'b0; cpu_we = 1'b0;
            end
            #1;
            exp = (c <= 2);
            checks++; if (cpu_stall !== exp) begin failures++; $display("FAIL store_stall c=%0d got=%0b exp=%0b", c, cpu_stall, exp); end
        end
        checks++; if (wr_mask[5] !== 1'b1 || ram[5] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL store_ram got=%0b/%0h exp=1/deadbeef", wr_mask[5], ram[5]);
        end
    endtask

    task automatic test_cpu_load();
        logic exp;
        for (int c = 0; c <= 4; c++) begin
            tick();
            exp = (c == 3);
            checks++; if (cpu_done !== exp) begin failures++; $display("FAIL load_done c=%0d got=%0b exp=%0b", c, cpu_done, exp); end
            checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL load_mem_we c=%0d got=%0b exp=0", c, mem_we); end
            if (c >= 3) begin
                checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata c=%0d got=%0h exp=deadbeef", c, cpu_rdata); end
            end
            if (c == 0) begin
                cpu_we = 1'b0; cpu_addr = 32'd5; cpu_req = 1'b1;
            end
            if (c == 3) cpu_req = 1'b0;
        end
        checks++; if (io_rdata !== 32'd0) begin failures++; $display("FAIL load_io_untouched got=%0h exp=0", io_rdata); end
    endtask

    task automatic test_simultaneous();
        int cpu_dc, io_dc;
        logic [ADDR_W-1:0] loser_addr;
        logic exp;
`ifdef ROUND_ROBIN_EN
        cpu_dc = 6; io_dc = 3; loser_addr = 32'd2;
`else
        cpu_dc = 3; io_dc = 6; loser_addr = 32'd7;
`endif
        for (int c = 0; c <= 7; c++) begin
            tick();
            exp = (c == cpu_dc);
            checks++; if (cpu_done !== exp) begin failures++; $display("FAIL simul_cpu_done c=%0d got=%0b exp=%0b", c, cpu_done, exp); end
            exp = (c == io_dc);
            checks++; if (io_done !== exp) begin failures++; $display("FAIL simul_io_done c=%0d got=%0b exp=%0b", c, io_done, exp); end
            if (c == 4) begin
                checks++; if (mem_addr !== loser_addr) begin failures++; $display("FAIL simul_loser_addr got=%0h exp=%0h", mem_addr, loser_addr); end
            end
            if (c == 0) begin
                cpu_we = 1'b0; cpu_addr = 32'd2; cpu_req = 1'b1;
                io_we  = 1'b0; io_addr  = 32'd7; io_req  = 1'b1;
            end
            if (c == cpu_dc) cpu_req = 1'b0;
            if (c == io_dc)  io_req  = 1'b0;
        end
        checks++; if (cpu_rdata !== 32'h1000_0002 || io_rdata !== 32'h1000_0007) begin
            failures++; $display("FAIL simul_rdata got=%0h/%0h exp=10000002/10000007", cpu_rdata, io_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_cpu, exp_io;
        int io_pulses;
        io_pulses = 0;
        for (int c = 0; c <= 17; c++) begin
            tick();
`ifdef ROUND_ROBIN_EN
            exp_cpu = (c == 6 || c == 12);
            exp_io  = (c == 3 || c == 9 || c == 15);
`else
            exp_cpu = (c == 3 || c == 6 || c == 9 || c == 12);
            exp_io  = (c == 15);
`endif
            checks++; if (cpu_done !== exp_cpu) begin failures++; $display("FAIL b2b_cpu_done c=%0d got=%0b exp=%0b", c, cpu_done, exp_cpu); end
            checks++; if (io_done !== exp_io) begin failures++; $display("FAIL b2b_io_done c=%0d got=%0b exp=%0b", c, io_done, exp_io); end
            if (c < 12 && io_done === 1'b1) io_pulses++;
            if (c == 0) begin
                cpu_we = 1'b0; cpu_addr = 32'd2; cpu_req = 1'b1;
                io_we  = 1'b0; io_addr  = 32'd7; io_req  = 1'b1;
            end
            if (c == 12) cpu_req = 1'b0;
            if (c == 15) io_req  = 1'b0;
        end
`ifdef ROUND_ROBIN_EN
        checks++; if (io_pulses !== 2) begin failures++; $display("FAIL b2b_io_count got=%0d exp=2", io_pulses); end
`else
        checks++; if (io_pulses !== 0) begin failures++; $display("FAIL b2b_io_count got=%0d exp=0", io_pulses); end
`endif
    endtask

    task automatic test_reset_mid();
        logic exp;
        tick();
        io_we = 1'b1; io_addr = 32'd9; io_wdata = 32'h1234_5678; io_req = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd9) begin
            failures++; $display("FAIL rmid_access got=%0b/%0h exp=1/9", mem_we, mem_addr);
        end
        reset = 1'b1; io_req = 1'b0; io_we = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rmid_we_drop got=%0b exp=0", mem_we); end
        tick();
        reset = 1'b0;
        checks++; if (io_rdata !== 32'd0 || cpu_rdata !== 32'd0) begin
            failures++; $display("FAIL rmid_rdata_reset got=%0h/%0h exp=0/0", io_rdata, cpu_rdata);
        end
        for (int c = 0; c <= 4; c++) begin
            tick();
            checks++; if (io_done !== 1'b0 || mem_we !== 1'b0) begin
                failures++; $display("FAIL rmid_aborted c=%0d got done=%0b we=%0b exp=0/0", c, io_done, mem_we);
            end
        end
        checks++; if (wr_mask[9] !== 1'b0) begin failures++; $display("FAIL rmid_no_write got=%0b exp=0", wr_mask[9]); end
        for (int c = 0; c <= 4; c++) begin
            tick();
            exp = (c == 1);
            checks++; if (mem_we !== exp) begin failures++; $display("FAIL rmid_retry_we c=%0d got=%0b exp=%0b", c, mem_we, exp); end
            exp = (c == 3);
            checks++; if (io_done !== exp) begin failures++; $display("FAIL rmid_retry_done c=%0d got=%0b exp=%0b", c, io_done, exp); end
            if (c == 0) begin
                io_we = 1'b1; io_addr = 32'd9; io_wdata = 32'h1234_5678; io_req = 1'b1;
            end
            if (c == 3) begin
                io_req = 1'b0; io_we = 1'b0;
            end
        end
        checks++; if (wr_mask[9] !== 1'b1 || ram[9] !== 32'h1234_5678) begin
            failures++; $display("FAIL rmid_retry_ram got=%0b/%0h exp=1/12345678", wr_mask[9], ram[9]);
        end
    endtask

    task automatic test_drop_in_access();
        logic exp;
        for (int c = 0; c <= 7; c++) begin
            tick();
            exp = (c == 3);
            checks++; if (cpu_done !== exp) begin failures++; $display("FAIL drop_done c=%0d got=%0b exp=%0b", c, cpu_done, exp); end
            if (c == 0) begin
                cpu_we = 1'b0; cpu_addr = 32'd5; cpu_req = 1'b1;
            end
            if (c == 1) cpu_req = 1'b0;
            if (c == 2) begin
                #1;
                checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL drop_stall got=%0b exp=0", cpu_stall); end
            end
        end
        checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL drop_rdata got=%0h exp=deadbeef", cpu_rdata); end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        io_req  = 1'b0; io_we  = 1'b0; io_addr  = '0; io_wdata  = '0;
        tick();
        test_reset();
        test_cpu_store();
        test_cpu_load();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_drop_in_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
